// File: rtl/shift_add_seq.sv
// shift_add_seq: sequencer and accumulator for a shift-and-add multiplier.
// Feeds an external ripple-carry add stage with the running upper partial
// product and the multiplicand gated by the current multiplier bit, waits a
// fixed adder latency, then shifts the sum and the recovered carry back into
// {acc, q}. After WIDTH bits the 2*WIDTH-bit product is published together
// with a one-cycle done pulse.
module shift_add_seq #(
    parameter int WIDTH   = 8,
    parameter int ADD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     add_sum,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]   BCNT_LAST = BW'(WIDTH - 1);
    localparam logic [2:0]      WCNT_LAST = 3'(ADD_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     q_q;
    logic [BW-1:0]        bcnt_q;
    logic [2:0]           wcnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 carry_s;
    logic [WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]     q_d;

    // Add-stage operands come straight from registers so they stay stable
    // for the whole wait; the carry is rebuilt from the operand and sum MSBs
    // because the add stage has no carry-out.
    always_comb begin
        add_a   = acc_q;
        add_b   = q_q[0] ? mcand_q : {WIDTH{1'b0}};
        carry_s = (acc_q[WIDTH-1] & add_b[WIDTH-1])
                | ((acc_q[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);
        acc_d   = {carry_s, add_sum[WIDTH-1:1]};
        q_d     = {add_sum[0], q_q[WIDTH-1:1]};
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

    // Control FSM and datapath registers; every bit waits the full adder
    // latency so the operation time does not depend on the operands.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            mcand_q   <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            bcnt_q    <= {BW{1'b0}};
            wcnt_q    <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= multiplicand;
                        q_q     <= multiplier;
                        acc_q   <= {WIDTH{1'b0}};
                        bcnt_q  <= {BW{1'b0}};
                        wcnt_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ADD: begin
                    if (wcnt_q != WCNT_LAST) begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end else begin
                        wcnt_q <= 3'd0;
                        acc_q  <= acc_d;
                        q_q    <= q_d;
                        if (bcnt_q == BCNT_LAST) begin
                            bcnt_q    <= {BW{1'b0}};
                            product_q <= {acc_d, q_d};
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            bcnt_q <= bcnt_q + BW'(1);
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_seq.md
Name: shift_add_seq

Overview:
- Sequencer and accumulator for the shift-and-add multiplier. It sits directly upstream of the registered ripple-carry add stage and also consumes that stage's output.
- Accepts an operand pair on a start handshake and drives the add stage with the running partial product and a gated multiplicand.
- Captures each sum after a configurable adder latency, shifts, and after WIDTH iterations presents the 2*WIDTH-bit product with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
ADD_LAT, 1, clock cycles from stable add_a/add_b to valid add_sum (range 0..7; 0 = combinational adder).

Ports:
clk  input  1  clock, rising edge.
res  input  1  asynchronous active-low reset.
start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
multiplicand  input  WIDTH  operand A; captured when start is accepted.
multiplier  input  WIDTH  operand B; captured when start is accepted.
add_sum  input  WIDTH  sum returned by the add stage.
add_a  output  WIDTH  partial-product accumulator to add stage (its result_in).
add_b  output  WIDTH  gated multiplicand to add stage.
busy  output  1  high while iterating.
done  output  1  one-cycle pulse when product becomes valid.
product  output  2*WIDTH  final product; holds until next completion.

Behaviour:
- Reset (res low, asynchronous):
  - state=IDLE; acc, q, mcand, bit and wait counters cleared.
  - busy=0, done=0, product=0, add_a=0, add_b=0.
  - Asserting reset mid-operation aborts; no partial product is ever published.
- Registers:
  - mcand (WIDTH) holds the captured multiplicand.
  - acc (WIDTH) is the upper half of the partial product.
  - q (WIDTH) starts as the multiplier and fills with product low bits.
  - bcnt counts 0..WIDTH-1; wcnt counts 0..ADD_LAT.
- Combinational outputs:
  - add_a = acc.
  - add_b = q[0] ? mcand : 0.
  - Both are driven from registers only and are stable for the whole ADD phase.
- Carry recovery: the add stage exposes no carry-out, so carry is derived as c = (add_a[W-1] & add_b[W-1]) | ((add_a[W-1] ^ add_b[W-1]) & ~add_sum[W-1]).
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at edge E0: load mcand, q=multiplier, acc=0, bcnt=0, wcnt=0; go to ADD.
- ADD (busy=1):
  - While wcnt < ADD_LAT: wcnt++ each edge.
  - On the edge with wcnt==ADD_LAT: {acc,q} <= {c, add_sum, q} >> 1 (2*WIDTH+1 bits shifted right by one, keep low 2*WIDTH); then wcnt=0, bcnt++.
  - That shift edge is therefore ADD_LAT+1 edges after entering the bit.
  - Zero multiplier bits still wait the full latency, so operation time is constant.
  - After the shift with bcnt==WIDTH-1: product <= shifted {acc,q}; go to DONE.
- Timing:
  - The final shift occurs at edge E0 + WIDTH*(ADD_LAT+1).
  - done is high for exactly the following cycle (W=8, L=1: done high after edge E0+16).
- DONE (done=1, busy=0):
  - start=1 is accepted exactly as in IDLE (back-to-back operation; product holds its value until the next completion).
  - Otherwise go to IDLE.
- start while busy is ignored; no queueing.
- Operand inputs matter only on the accepting edge.
- Result is unsigned WIDTH x WIDTH; the 2*WIDTH-bit product never overflows.

Test Plan:
- Reset: hold res low, toggle clk and start -> all outputs 0 and state stays IDLE; release res, no start -> outputs stay 0.
- 0xFF*0xFF, ADD_LAT=1 -> busy high for 16 cycles, done one cycle after edge E0+16, product=0xFE01.
- Carry path: 0x80*0x03 then 0xFF*0x01 -> product=0x0180 and 0x00FF; add_a/add_b match the expected gated operand each iteration.
- Zero operands: 0x00*0xA5 and 0x5A*0x00 -> product=0x0000; latency unchanged at 16 cycles.
- Back-to-back with start held high through DONE, 0x0C*0x0D then 0x07*0x09 -> second start accepted in DONE cycle; products 0x009C then 0x003F; start pulses while busy have no effect.
- Reset mid-op: assert res at cycle 7 of 0xFF*0xFF -> immediate zero outputs, no done pulse; a fresh 0x03*0x05 yields 0x000F. Repeat directed cases with ADD_LAT=0 (done after edge E0+8) and ADD_LAT=3 (after edge E0+32).
